bus_regfile_periph: RTL and testbench

Parametrised memory-mapped register-file peripheral for the shared CPU bus, the successor to the fixed 4-entry test peripheral. It has a configurable number of storage registers and independent, run-time programmable read and write wait-state counts. It also provides a read-only write-count status register and guarantees exactly one write commit per chip-enable assertion. It sits behind the top-level address decoder, one instance per bus region, and shares the tri-state data bus and the open-drain `buswait_n` line with the other peripherals.

---
 rtl/bus_regfile_periph.sv | 138 +++++++++++++
 tb/tb_bus_regfile_periph.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_regfile_periph.sv
// Memory-mapped register file with programmable read/write wait states, a
// committed-write counter and one write commit per chip-enable assertion.
module bus_regfile_periph #(
  parameter logic [3:0] ID         = 4'h0,
  parameter int         DATA_WIDTH = 8,
  parameter int         ADDR_WIDTH = 15,
  parameter int         DEPTH      = 4,
  parameter int         RD_WAIT    = 0,
  parameter int         WR_WAIT    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd_n,
  input  logic                  wr_n,
  inout  wire  [DATA_WIDTH-1:0] data,
  output wire                   buswait_n
);

  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = ADDR_WIDTH'(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  w_commit;
  logic                  w_wait;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [3:0]            r_rdw;
  logic [3:0]            r_wrw;
  logic [DATA_WIDTH-1:0] r_status;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_acc;
  logic                  w_oor;
  logic [3:0]            w_n;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_rd  = !ce_n && !rd_n &&  wr_n;
  assign w_wr  = !ce_n && !wr_n &&  rd_n;
  assign w_acc = w_rd || w_wr;
  assign w_oor = addr > STAT_ADDR;

  always_comb begin
    w_n = '0;
    if (!w_oor) begin
      if (w_rd)      w_n = r_rdw;
      else if (w_wr) w_n = r_wrw;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_n != 4'd0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = w_n - 4'd1;
          end else begin
            w_state_nxt = S_HOLD;
            w_commit    = w_wr;
          end
        end
      end
      S_WAIT: begin
        if (ce_n) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = S_HOLD;
          w_commit    = w_wr;
        end
      end
      S_HOLD: begin
        if (ce_n) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Wait is purely combinational so abort/reset release it without an edge.
  always_comb begin
    w_wait = reset_n && w_acc &&
             (((r_state == S_IDLE) && (w_n != 4'd0)) ||
              ((r_state == S_WAIT) && (r_cnt != 4'd0)));
  end

  assign buswait_n = w_wait ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        r_mem[i] <= (DATA_WIDTH'(ID) << (DATA_WIDTH - 4)) | DATA_WIDTH'(i);
      r_rdw    <= 4'(RD_WAIT);
      r_wrw    <= 4'(WR_WAIT);
      r_status <= '0;
    end else if (w_commit) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (addr == ADDR_WIDTH'(i)) r_mem[i] <= data;
      if (addr == CTRL_ADDR) begin
        r_rdw <= data[7:4];
        r_wrw <= data[3:0];
      end
      if (addr <= CTRL_ADDR) r_status <= r_status + DATA_WIDTH'(1);
    end
  end

  always_comb begin
    w_rdata = '1;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (addr == ADDR_WIDTH'(i)) w_rdata = r_mem[i];
    if (addr == CTRL_ADDR) w_rdata = DATA_WIDTH'({r_rdw, r_wrw});
    if (addr == STAT_ADDR) w_rdata = r_status;
  end

  assign data = (reset_n && w_rd) ? w_rdata : 'z;

endmodule

// File: tb/tb_bus_regfile_periph.sv
// Randomised scoreboard bench for bus_regfile_periph against an array-based
// reference model; a negedge monitor measures each access independently.
module tb_bus_regfile_periph;
  localparam int DW    = 8;
  localparam int AW    = 15;
  localparam int DEPTH = 4;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce_n    = 1'b1;
  logic          rd_n    = 1'b1;
  logic          wr_n    = 1'b1;
  logic [AW-1:0] addr    = '0;
  logic [DW-1:0] tb_data = '0;
  logic          tb_drv  = 1'b0;
  wire  [DW-1:0] data;
  wire           buswait_n;

  assign data = tb_drv ? tb_data : 'z;
  pullup   (buswait_n);
  pulldown (data);

  bus_regfile_periph #(
    .ID(4'h1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .RD_WAIT(0), .WR_WAIT(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce_n(ce_n), .addr(addr),
    .rd_n(rd_n), .wr_n(wr_n), .data(data), .buswait_n(buswait_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference model
  logic [7:0] m_mem [DEPTH];
  logic [3:0] m_rdw, m_wrw;
  logic [7:0] m_status;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h10 | 8'(i);
    m_rdw    = 4'd0;
    m_wrw    = 4'd2;
    m_status = 8'd0;
  endfunction

  function automatic logic [7:0] model_read(input logic [AW-1:0] a);
    if (a < DEPTH)          return m_mem[a[1:0]];
    else if (a == DEPTH)    return {m_rdw, m_wrw};
    else if (a == DEPTH+1)  return m_status;
    else                    return 8'hFF;
  endfunction

  function automatic int model_wait(input int kind, input logic [AW-1:0] a);
    if (kind == 2 || a > DEPTH + 1) return 0;
    return (kind == 0) ? int'(m_rdw) : int'(m_wrw);
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [7:0] d);
    if (a < DEPTH)       m_mem[a[1:0]] = d;
    else if (a == DEPTH) {m_rdw, m_wrw} = d;
    if (a <= DEPTH)      m_status = m_status + 8'd1;
  endfunction

  typedef struct {
    int         waits;
    bit         chk_data;
    logic [7:0] d;
    string      tag;
  } exp_t;
  exp_t exp_q[$];

  // Monitor
  bit         mon_act = 1'b0;
  int         mon_waits;
  logic [7:0] mon_d;
  bit         mon_unstable;

  always @(negedge clk) begin
    exp_t e;
    if (!ce_n) begin
      if (!mon_act) begin
        mon_act      = 1'b1;
        mon_waits    = 0;
        mon_d        = data;
        mon_unstable = 1'b0;
      end else if (data !== mon_d) begin
        mon_unstable = 1'b1;
      end
      if (buswait_n === 1'b0) mon_waits++;
    end else if (mon_act) begin
      mon_act = 1'b0;
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk({e.tag, " wait_edges"}, mon_waits, e.waits);
        if (e.chk_data)
          chk({e.tag, " read_data"}, mon_unstable ? -1 : int'(mon_d), int'(e.d));
        chk({e.tag, " bus_release"}, int'({buswait_n, data}), int'(9'h100));
      end
    end
  end

  task automatic end_acc();
    ce_n   = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    tb_drv = 1'b0;
  endtask

  // kind: 0 read, 1 write, 2 both strobes low
  task automatic do_access(input int kind, input logic [AW-1:0] a, input logic [7:0] wd,
                           input int hold, input int abort_k, input bit do_rst,
                           input string tag);
    exp_t e;
    int   n;
    int   t;
    n          = model_wait(kind, a);
    e.waits    = (abort_k > 0) ? abort_k : n;
    e.chk_data = (kind != 1) && !do_rst;
    e.d        = (kind == 0) ? model_read(a) : 8'h00;
    e.tag      = tag;
    exp_q.push_back(e);

    @(posedge clk); #1;
    ce_n    = 1'b0;
    addr    = a;
    rd_n    = !(kind == 0 || kind == 2);
    wr_n    = !(kind == 1 || kind == 2);
    tb_drv  = (kind == 1);
    tb_data = wd;

    if (abort_k > 0) begin
      repeat (abort_k) @(posedge clk);
      #1;
      if (do_rst) begin
        reset_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        end_acc();
        @(posedge clk); #1;
        reset_n = 1'b1;
      end else begin
        end_acc();
      end
    end else begin
      t = 0;
      forever begin
        @(negedge clk);
        if (buswait_n !== 1'b0) break;
        t++;
        if (t > 40) begin
          chk({tag, " wait_timeout"}, t, 40);
          break;
        end
      end
      @(posedge clk);
      if (kind == 1) model_write(a, wd);
      repeat (hold) begin
        #1;
        if (kind == 1) begin
          wr_n    = 1'($urandom_range(0, 1));
          tb_data = 8'($urandom);
        end
        @(posedge clk);
      end
      #1;
      end_acc();
    end
  endtask

  int         kind, hold, ak, nw;
  bit         rst;
  logic [AW-1:0] ra;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < DEPTH + 2; i++) do_access(0, AW'(i), 8'h00, 0, 0, 0, "reset_read");

    do_access(1, 15'd1, 8'h99, 5, 0, 0, "wr_99_hold");
    do_access(0, 15'd1, 8'h00, 0, 0, 0, "rd_addr1");
    do_access(0, 15'd5, 8'h00, 0, 0, 0, "rd_status1");

    do_access(1, 15'd4, 8'h31, 0, 0, 0, "wr_ctrl31");
    do_access(0, 15'd0, 8'h00, 1, 0, 0, "rd_wait3");
    do_access(1, 15'd3, 8'hAB, 0, 0, 0, "wr_wait1");

    do_access(1, 15'd2, 8'h55, 0, 1, 0, "abort_wr");
    do_access(0, 15'd2, 8'h00, 0, 0, 0, "rd_after_abort");
    do_access(0, 15'd5, 8'h00, 0, 0, 0, "rd_status_abort");

    do_access(2, 15'd0, 8'h00, 0, 0, 0, "illegal");
    do_access(0, 15'd7, 8'h00, 0, 0, 0, "rd_oor");
    do_access(1, 15'd6, 8'h42, 0, 0, 0, "wr_oor");
    do_access(1, 15'd5, 8'h42, 0, 0, 0, "wr_status");
    do_access(0, 15'd5, 8'h00, 0, 0, 0, "rd_status_ro");

    do_access(1, 15'd0, 8'h77, 0, 1, 1, "reset_midwait");
    for (int i = 0; i < DEPTH + 2; i++) do_access(0, AW'(i), 8'h00, 0, 0, 0, "post_reset");

    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 4) ? 0 : (kind < 8) ? 1 : 2;
      ra   = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      hold = $urandom_range(0, 3);
      nw   = model_wait(kind, ra);
      ak   = 0;
      rst  = 1'b0;
      if (nw > 0 && $urandom_range(0, 4) == 0) begin
        ak  = $urandom_range(1, nw);
        rst = ($urandom_range(0, 5) == 0);
      end
      do_access(kind, ra, 8'($urandom), hold, ak, rst, "random");
    end

    do_access(1, 15'd4, 8'h00, 0, 0, 0, "wrap_ctrl0");
    for (int i = 0; i < 260; i++) do_access(1, 15'd3, 8'($urandom), 0, 0, 0, "wrap_wr");
    do_access(0, 15'd5, 8'h00, 0, 0, 0, "rd_status_wrap");
    do_access(0, 15'd3, 8'h00, 0, 0, 0, "rd_wrap_data");

    repeat (3) @(posedge clk);
    chk("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
